// File: rtl/sencilla_control_if.sv
// RAM-side bus of the sencilla core: address, write data, write enable and
// the RAM's combinational read data.
interface sencilla_control_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] sal;
  logic [ADDR_W-1:0] dir;
  logic [DATA_W-1:0] ent;
  logic              le;

  modport master (input sal, output dir, output ent, output le);
  modport slave  (output sal, input dir, input ent, input le);
endinterface

// File: rtl/sencilla_control.sv
// Multi-cycle fetch/decode/execute core for the 4-instruction memory-to-memory
// ISA (ADD, CMP, MOV, BEQ) driving a single-port RAM with combinational read.
module sencilla_control #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16,
  parameter int PC_RESET = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  sencilla_control_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              z,
  output logic              fetch
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_RD_F   = 3'd2;
  localparam logic [2:0] S_RD_D   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  // Two's-complement add with the carry discarded.
  function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y);
    return x + y;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              z_q, z_d;

  logic [1:0]        op;
  logic [ADDR_W-1:0] fld_f;
  logic [ADDR_W-1:0] fld_d;
  logic [DATA_W-1:0] sum;

  assign op    = ir_q[DATA_W-1 -: 2];
  assign fld_f = ir_q[2*ADDR_W-1 -: ADDR_W];
  assign fld_d = ir_q[ADDR_W-1:0];
  assign sum   = add_wrap(a_q, b_q);

  // Bus outputs depend only on registered state, so a frozen core keeps dir
  // steady and an async reset drops le before the next edge.
  always_comb begin
    bus.dir = pc_q;
    bus.ent = '0;
    bus.le  = 1'b0;
    unique case (state_q)
      S_FETCH:  bus.dir = pc_q;
      S_DECODE: bus.dir = fld_d;
      S_RD_F:   bus.dir = fld_f;
      S_RD_D:   bus.dir = fld_d;
      S_WB: begin
        bus.dir = fld_d;
        bus.le  = en;
        bus.ent = (op == OP_ADD) ? sum : a_q;
      end
      default:  bus.dir = pc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    unique case (state_q)
      S_FETCH: begin
        ir_d    = bus.sal;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op == OP_BEQ) begin
          if (z_q) pc_d = fld_d;
          state_d = S_FETCH;
        end else begin
          state_d = S_RD_F;
        end
      end
      S_RD_F: begin
        a_d     = bus.sal;
        state_d = (op == OP_MOV) ? S_WB : S_RD_D;
      end
      S_RD_D: begin
        b_d = bus.sal;
        if (op == OP_CMP) begin
          z_d     = (a_q == bus.sal);
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (op == OP_ADD) z_d = (sum == '0);
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= ADDR_W'(PC_RESET);
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
    end
  end

  assign pc    = pc_q;
  assign ir    = ir_q;
  assign z     = z_q;
  assign fetch = (state_q == S_FETCH);

endmodule

// File: doc/sencilla_control.md
Name: sencilla_control

Overview:
- Fetch/decode/execute core for the simple machine. Sits directly upstream of the 128x16 program/data RAM.
- Drives the RAM address, write-data and write-enable; consumes its combinational read data.
- Executes the 4-instruction ISA (ADD, CMP, MOV, BEQ) over memory-to-memory operands and holds the Z flag.

Parameters:
- ADDR_W, 7, RAM address width; also the width of each operand field and of the PC.
- DATA_W, 16, RAM word width. Must equal 2+2*ADDR_W.
- PC_RESET, 0, PC value loaded on reset (first instruction address).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  run enable; when low the core freezes.
- sal  input  DATA_W  RAM read data, combinational from dir.
- dir  output  ADDR_W  RAM address.
- ent  output  DATA_W  RAM write data.
- le  output  1  RAM write enable; RAM writes on the rising edge of clk.
- pc  output  ADDR_W  current program counter.
- ir  output  DATA_W  current instruction register.
- z  output  1  zero flag.
- fetch  output  1  high during the FETCH state (instruction boundary, for debug/IO sync).

Behaviour:
- Instruction format: op=ir[15:14], F=ir[13:7] (source address), D=ir[6:0] (destination address).
- Opcodes:
  - 00 ADD: M[D]<=M[D]+M[F]; Z updated.
  - 01 CMP: Z<=(M[F]==M[D]); no write.
  - 10 MOV: M[D]<=M[F]; Z unchanged.
  - 11 BEQ: if Z, PC<=D; F ignored.
- Registers: pc, ir, A (source operand), B (destination operand), z, state. All cleared asynchronously by reset: pc=PC_RESET, ir=0, A=0, B=0, z=0, state=FETCH.
- Outputs after reset: dir=PC_RESET, le=0, ent=0, fetch=1.
- dir, le, ent and fetch are combinational from state/registers. Read data is used in the same cycle that dir is presented.
- States and per-state actions:
  - FETCH: dir=pc; ir<=sal; pc<=pc+1 (mod 2^ADDR_W; 127 wraps to 0). Next: DECODE.
  - DECODE: dir=D. If op=11, pc<=D when z=1; next FETCH. Otherwise next RD_F.
  - RD_F: dir=F; A<=sal. Next: WB if MOV, else RD_D.
  - RD_D: dir=D; B<=sal. If CMP: z<=(A==sal), next FETCH. If ADD: next WB.
  - WB: dir=D; le=1. ent=A+B (ADD, modulo 2^16, carry discarded) or ent=A (MOV). For ADD, z<=(A+B)[15:0]==0. Next: FETCH.
- ent=0 in every state other than WB. le=1 only in WB with en=1.
- Cycle counts per instruction: ADD 5, MOV 4, CMP 4, BEQ 2.
- en=0: state and all registers hold, le forced 0, dir holds its current value. Resumes exactly where stopped.
- Reset asserted mid-instruction, including during WB: state returns to FETCH immediately and le drops combinationally, so no write occurs on the next edge. The partial instruction is abandoned; z is cleared.
- Self-referencing operands (F==D) are legal. ADD doubles M[D]; MOV is a no-op write.
- Instructions may overwrite program memory. The next fetch sees the new word.
- No halt instruction. Programs end in a BEQ self-loop (CMP X,X sets z=1).

Test Plan:
- Reset: hold reset, en=1 -> pc=0, z=0, ir=0, dir=0, le=0, fetch=1. Release reset -> ir<=M[0] on the first edge, pc=1.
- MOV: M[0]=10_1100100_1100101 (MOV 100->101), M[100]=16'h1234 -> after 4 cycles M[101]=16'h1234, z unchanged. le high for exactly 1 cycle with dir=101.
- ADD, zero/carry: M[100]=16'hFFFF, M[101]=16'h0001, ADD 100,101 -> M[101]=16'h0000, z=1. Second case with M[100]=3, M[101]=4 -> M[101]=7, z=0. Each instruction takes 5 cycles.
- CMP/BEQ: M[102]=M[103]=5; CMP 102,103 then BEQ 20 -> z=1, pc=20. Repeat with M[103]=6 -> z=0, pc falls through to 2.
- PC wrap and en freeze: PC_RESET=127, M[127]=MOV -> after fetch pc=0. Deassert en for 3 cycles during RD_F -> state, dir and pc frozen, le=0. Completes normally after en returns high.
- Reset during WB: assert reset while le=1 in ADD WB -> le drops immediately, M[D] unchanged, pc=PC_RESET after release.
